// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch stage
package fetch_pkg;

  localparam int INSTR_W = 9;

  // R-type with funct 4'b1111; the decoder treats it as a no-op
  localparam logic [INSTR_W-1:0] DEFAULT_HALT_INSTR = 9'h0FF;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    RUN,
    HALT
  } fetch_state_t;

  typedef enum logic [1:0] {
    PC_HOLD,
    PC_LOAD,
    PC_INC
  } pc_sel_t;

endpackage

// File: rtl/fetch_if.sv
// rtl/fetch_if.sv - synchronous-read instruction memory bus
interface fetch_if #(
  parameter int PC_W = 10
);
  import fetch_pkg::*;

  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_data;

  modport master (output imem_addr, input imem_data);
  modport slave  (input imem_addr, output imem_data);

endinterface

// File: rtl/pc_reg.sv
// rtl/pc_reg.sv - program counter register with load/hold/increment select
module pc_reg
  import fetch_pkg::*;
#(
  parameter int PC_W = 10
) (
  input  logic            clk,
  input  logic            rst_n,
  input  pc_sel_t         sel_i,
  input  logic [PC_W-1:0] load_addr_i,
  output logic [PC_W-1:0] pc_o
);

  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;

  // Increment wraps naturally at 2^PC_W
  always_comb begin
    pc_d = pc_q;
    case (sel_i)
      PC_LOAD: pc_d = load_addr_i;
      PC_INC:  pc_d = pc_q + PC_W'(1);
      default: pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - fetch stage FSM and next-address mux; FETCH_CYCLE_COUNT_EN adds the cycle counter
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                 PC_W       = 10,
  parameter logic [PC_W-1:0]    START_ADDR = '0,
  parameter logic [INSTR_W-1:0] HALT_INSTR = DEFAULT_HALT_INSTR
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic               stall_i,
  input  logic               branch_en_i,
  input  logic [PC_W-1:0]    branch_target_i,
  fetch_if.master            imem,
  output logic [INSTR_W-1:0] instr_o,
  output logic               instr_valid_o,
  output logic [PC_W-1:0]    pc_o,
  output logic               done_o,
  output logic [15:0]        cycle_count_o
);

  fetch_state_t    state_q;
  logic            instr_valid_q;
  logic            done_q;
  logic            is_halt;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] next_addr;
  logic [PC_W-1:0] load_addr;
  pc_sel_t         pc_sel;

  assign is_halt = (state_q == RUN) && instr_valid_q && (imem.imem_data == HALT_INSTR);

  // Branch reaches imem_addr combinationally so a taken branch costs no bubble
  always_comb begin
    next_addr = pc;
    pc_sel    = PC_HOLD;
    if ((state_q == RUN) && !is_halt && !stall_i) begin
      if (branch_en_i) begin
        next_addr = branch_target_i;
        pc_sel    = PC_LOAD;
      end else begin
        next_addr = pc + PC_W'(1);
        pc_sel    = PC_INC;
      end
    end
    if (start_i) begin
      pc_sel = PC_LOAD;
    end
  end

  assign load_addr = start_i ? START_ADDR : branch_target_i;

  pc_reg #(.PC_W(PC_W)) u_pc_reg (
    .clk         (clk),
    .rst_n       (rst_n),
    .sel_i       (pc_sel),
    .load_addr_i (load_addr),
    .pc_o        (pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      instr_valid_q <= 1'b0;
      done_q        <= 1'b0;
    end else if (start_i) begin
      state_q       <= FILL;
      instr_valid_q <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      case (state_q)
        FILL: begin
          state_q       <= RUN;
          instr_valid_q <= 1'b1;
        end
        RUN: begin
          if (is_halt) begin
            state_q       <= HALT;
            instr_valid_q <= 1'b0;
            done_q        <= 1'b1;
          end
        end
        default: begin
          state_q <= state_q;
        end
      endcase
    end
  end

`ifdef FETCH_CYCLE_COUNT_EN
  logic [15:0] cycle_count_q;

  // The halt cycle executes even if stall happens to be high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_count_q <= '0;
    end else if (start_i) begin
      cycle_count_q <= '0;
    end else if ((state_q == RUN) && (!stall_i || is_halt) && (cycle_count_q != 16'hFFFF)) begin
      cycle_count_q <= cycle_count_q + 16'd1;
    end
  end

  assign cycle_count_o = cycle_count_q;
`else
  assign cycle_count_o = '0;
`endif

  assign imem.imem_addr = next_addr;
  assign instr_o        = imem.imem_data;
  assign instr_valid_o  = instr_valid_q;
  assign pc_o           = pc;
  assign done_o         = done_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized fetch_unit bench against a behavioural program-execution model
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int PC_W  = 10;
  localparam int DEPTH = 1 << PC_W;
`ifdef FETCH_CYCLE_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start_i = 1'b0;
  logic            stall_i = 1'b0;
  logic            branch_en_i = 1'b0;
  logic [PC_W-1:0] branch_target_i = '0;
  logic [8:0]      instr_o;
  logic            instr_valid_o;
  logic [PC_W-1:0] pc_o;
  logic            done_o;
  logic [15:0]     cycle_count_o;

  logic [8:0] mem [DEPTH];
  logic [8:0] mem_q;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: filling / live / done flags, current pc and executed-cycle count
  bit m_fill = 1'b0;
  bit m_live = 1'b0;
  bit m_done = 1'b0;
  int m_pc   = 0;
  int m_cnt  = 0;

  fetch_if #(.PC_W(PC_W)) bus ();

  fetch_unit #(
    .PC_W       (PC_W),
    .START_ADDR ('0),
    .HALT_INSTR (9'h0FF)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start_i         (start_i),
    .stall_i         (stall_i),
    .branch_en_i     (branch_en_i),
    .branch_target_i (branch_target_i),
    .imem            (bus),
    .instr_o         (instr_o),
    .instr_valid_o   (instr_valid_o),
    .pc_o            (pc_o),
    .done_o          (done_o),
    .cycle_count_o   (cycle_count_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) mem_q <= mem[bus.imem_addr];
  assign bus.imem_data = mem_q;

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int sat_inc(int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  task automatic model_step();
    if (!rst_n) begin
      m_fill = 1'b0; m_live = 1'b0; m_done = 1'b0; m_pc = 0; m_cnt = 0;
    end else if (start_i) begin
      m_fill = 1'b1; m_live = 1'b0; m_done = 1'b0; m_pc = 0; m_cnt = 0;
    end else if (m_fill) begin
      m_fill = 1'b0; m_live = 1'b1;
    end else if (m_live) begin
      if (mem[m_pc] == 9'h0FF) begin
        m_live = 1'b0; m_done = 1'b1; m_cnt = sat_inc(m_cnt);
      end else if (!stall_i) begin
        m_pc  = branch_en_i ? int'(branch_target_i) : (m_pc + 1) % DEPTH;
        m_cnt = sat_inc(m_cnt);
      end
    end
  endtask

  function automatic int exp_addr();
    if (m_live && (mem[m_pc] != 9'h0FF) && !stall_i)
      return branch_en_i ? int'(branch_target_i) : (m_pc + 1) % DEPTH;
    return m_pc;
  endfunction

  initial forever begin
    @(posedge clk or negedge rst_n);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    #3;
    if (rst_n) begin
      chk("instr_valid", 32'(instr_valid_o), 32'(m_live));
      chk("pc", 32'(pc_o), 32'(m_pc));
      chk("done", 32'(done_o), 32'(m_done));
      chk("cycle_count", 32'(cycle_count_o), CNT_EN ? 32'(m_cnt) : 32'd0);
      if (m_live) chk("instr", 32'(instr_o), 32'(mem[m_pc]));
      if (!(m_live && start_i)) chk("imem_addr", 32'(bus.imem_addr), 32'(exp_addr()));
    end
  end

  task automatic drive(bit st, bit sl, bit be, int tgt);
    start_i         = st;
    stall_i         = sl;
    branch_en_i     = be;
    branch_target_i = PC_W'(tgt);
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      int v;
      v = $urandom_range(0, 510);
      if (v == 255) v = 256;
      mem[i] = 9'(v);
    end
    mem[0] = 9'h003;
    mem[1] = 9'h004;
    mem[2] = 9'h0FF;

    #12;
    chk("rst_pc", 32'(pc_o), 32'd0);
    chk("rst_imem_addr", 32'(bus.imem_addr), 32'd0);
    chk("rst_valid", 32'(instr_valid_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_count", 32'(cycle_count_o), 32'd0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;

    // Straight-line program 3, 4, halt
    drive(1, 0, 0, 0);
    chk("fill_valid", 32'(instr_valid_o), 32'd0);
    chk("fill_addr", 32'(bus.imem_addr), 32'd0);
    drive(0, 0, 0, 0);
    chk("first_valid", 32'(instr_valid_o), 32'd1);
    chk("first_pc", 32'(pc_o), 32'd0);
    chk("first_instr", 32'(instr_o), 32'h003);
    drive(0, 0, 0, 0);
    chk("second_pc", 32'(pc_o), 32'd1);
    chk("second_instr", 32'(instr_o), 32'h004);
    drive(0, 0, 0, 0);
    chk("third_pc", 32'(pc_o), 32'd2);
    drive(0, 0, 0, 0);
    chk("halt_done", 32'(done_o), 32'd1);
    chk("halt_pc", 32'(pc_o), 32'd2);
    chk("halt_count", 32'(cycle_count_o), CNT_EN ? 32'd3 : 32'd0);
    drive(0, 0, 0, 0);
    chk("halt_pc_hold", 32'(pc_o), 32'd2);

    // Same program with two stall cycles at pc 0
    drive(1, 0, 0, 0);
    chk("restart_done_clr", 32'(done_o), 32'd0);
    drive(0, 0, 0, 0);
    drive(0, 1, 0, 0);
    drive(0, 1, 0, 0);
    chk("stall0_pc", 32'(pc_o), 32'd0);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    chk("stall_prog_done", 32'(done_o), 32'd1);
    chk("stall_prog_count", 32'(cycle_count_o), CNT_EN ? 32'd3 : 32'd0);

    // Branches, stall at 5, restart at 7
    drive(1, 0, 0, 0);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    drive(0, 0, 1, 10);
    chk("br_pc", 32'(pc_o), 32'd10);
    chk("br_valid", 32'(instr_valid_o), 32'd1);
    chk("br_instr", 32'(instr_o), 32'(mem[10]));
    drive(0, 0, 1, 5);
    for (int k = 0; k < 3; k++) begin
      drive(0, 1, 0, 0);
      chk("stall5_pc", 32'(pc_o), 32'd5);
      chk("stall5_addr", 32'(bus.imem_addr), 32'd5);
      chk("stall5_instr", 32'(instr_o), 32'(mem[5]));
    end
    drive(0, 0, 0, 0);
    chk("resume_pc", 32'(pc_o), 32'd6);
    drive(0, 0, 0, 0);
    chk("pc7", 32'(pc_o), 32'd7);
    drive(1, 0, 0, 0);
    chk("midrun_fill_valid", 32'(instr_valid_o), 32'd0);
    drive(0, 0, 0, 0);
    chk("midrun_restart_pc", 32'(pc_o), 32'd0);

    // PC wrap from 1023
    drive(0, 0, 1, 1023);
    chk("wrap_top_pc", 32'(pc_o), 32'd1023);
    drive(0, 0, 0, 0);
    chk("wrap_pc", 32'(pc_o), 32'd0);
    chk("wrap_instr", 32'(instr_o), 32'h003);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    chk("wrap_done", 32'(done_o), 32'd1);

    // Asynchronous reset mid-run
    drive(1, 0, 0, 0);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_pc", 32'(pc_o), 32'd0);
    chk("arst_addr", 32'(bus.imem_addr), 32'd0);
    chk("arst_valid", 32'(instr_valid_o), 32'd0);
    chk("arst_done", 32'(done_o), 32'd0);
    chk("arst_count", 32'(cycle_count_o), 32'd0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    chk("arst_needs_start", 32'(instr_valid_o), 32'd0);

    // Randomized run
    for (int n = 0; n < 3000; n++) begin
      bit st;
      st = ((!m_live && !m_fill) && ($urandom_range(0, 2) == 0)) || ($urandom_range(0, 49) == 0);
      drive(st, $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 2, int'($urandom_range(0, DEPTH - 1)));
    end
    drive(0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage directly upstream of the control unit. Holds the program counter, drives a synchronous-read instruction memory, and presents the 9-bit instruction word to the control unit decoder. Consumes the decoder's `branchEnable` together with a resolved absolute target, and sequences a program from `start` to `done` via a halt instruction.

## Interface
- `PC_W`, 10: program counter and instruction memory address width.
- `START_ADDR`, 0: address loaded into the PC on `start`.
- `HALT_INSTR`, 9'h0FF: halt encoding, R-type with funct 4'b1111, which the decoder treats as a no-op.

Ports:
- `clk` input 1: clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: single-cycle pulse that begins or restarts program execution.
- `stall` input 1: holds the PC and the current instruction.
- `branch_en` input 1: taken-branch indication from the control unit for the current `instr`.
- `branch_target` input PC_W: absolute target address, valid whenever `branch_en`=1.
- `imem_addr` output PC_W: instruction memory read address.
- `imem_data` input 9: memory read data, returned one cycle after its address is presented.
- `instr` output 9: current instruction to the decoder; equals `imem_data`.
- `instr_valid` output 1: `instr` is a live instruction.
- `pc` output PC_W: address of the current `instr`.
- `done` output 1: program has halted.
- `cycle_count` output 16: executed-cycle count; feature-gated (see Configuration).

## Operation
- FSM states:
  - IDLE: waits for `start`.
  - FILL: `imem_addr`=`pc`, `instr_valid`=0, one cycle only, then → RUN.
  - RUN: normal fetch and execute.
  - HALT: `done`=1, waits for `start`.
- From IDLE or HALT, `start`=1 → FILL and `pc`<=START_ADDR. In FILL, `imem_addr` presents START_ADDR.
- RUN, `instr_valid`=1, next-fetch selection by priority:
  - `instr`==HALT_INSTR → HALT. `branch_en` and `stall` are ignored. `pc` holds. `imem_addr`=`pc`.
  - else if `stall` → `imem_addr`=`pc`, and `pc` holds (the memory re-reads the same word).
  - else if `branch_en` → `imem_addr`=`branch_target`, `pc`<=`branch_target`.
  - else `imem_addr`=`pc`+1, `pc`<=`pc`+1.
- `imem_addr` is combinational in RUN. This is the single combinational path from `branch_en` to `imem_addr`.
- The PC increments modulo 2^PC_W; 2^PC_W−1 wraps to 0 with no flag.
- `start` during RUN or FILL restarts: → FILL, `pc`<=START_ADDR. Any pending branch is discarded.
- In IDLE and HALT, `instr_valid`=0 and `imem_addr`=`pc`.
- `done` clears on the cycle after `start` is accepted.

## Timing
- Reset values (asynchronous, while `rst_n`=0):
  - state=IDLE
  - `pc`=0, `imem_addr`=0
  - `instr_valid`=0, `done`=0
  - `cycle_count`=0
- Start-to-first-instruction latency:
  - Edge 1 samples `start`; FILL follows.
  - Edge 2 enters RUN.
  - `instr_valid`=1 from the cycle after edge 2.
- Branch penalty is zero. A taken branch sampled at edge N gives `instr`=mem[`branch_target`] after edge N.
- Stall release resumes with no bubble.
- Reset asserted mid-RUN: all outputs reach reset values immediately; `start` is required afterwards.

## Configuration
- Macro: `FETCH_CYCLE_COUNT_EN`.
- Defined:
  - `cycle_count` increments on every RUN cycle with `stall`=0, including the halt cycle.
  - The count saturates at 16'hFFFF.
  - The count clears when `start` is accepted.
- Undefined: no counter register is built, and `cycle_count` is tied to 0.

## Structure
- Package `fetch_pkg`:
  - state enum `fetch_state_t` {IDLE, FILL, RUN, HALT}
  - `INSTR_W`=9
  - default `HALT_INSTR` constant
- Sub-module `pc_reg`: PC register with asynchronous active-low reset and load/hold/increment select. The next-address mux and the FSM stay in `fetch_unit`.

## Test plan
- Reset then `start` with START_ADDR=0 and mem[0..3]={9'h003, 9'h004, 9'h0FF, x}:
  - `instr_valid` rises 2 cycles after the `start` pulse.
  - `pc` reads 0, 1, 2.
  - `done`=1 after the halt; `pc` holds 2.
- `branch_en`=1 with `branch_target`=10 at `pc`=1: next `pc`=10, `instr`=mem[10], and no bubble occurs.
- `stall` held 3 cycles at `pc`=5: `pc`, `instr` and `imem_addr` stay 5 / mem[5] / 5, then resume at 6.
- `pc`=1023 with PC_W=10 and no branch: next `pc`=0.
- `start` asserted mid-RUN at `pc`=7: the next cycle is FILL with `instr_valid`=0, then `pc`=START_ADDR. Separately, `rst_n` pulsed low mid-RUN gives all outputs 0 immediately.
- With `FETCH_CYCLE_COUNT_EN`, a 3-instruction program plus 2 stall cycles gives `cycle_count`=3 at `done`. Without the macro, `cycle_count` reads 0.
